req_arbiter8: RTL
=================

Name: req_arbiter8

Overview:
- Clocked arbiter that shares one resource among 8 requesters and issues a single registered grant.
- Supports two modes: fixed priority and round-robin.
- Fixed priority matches the 8-to-3 priority encoder ordering: the highest index wins.
- Enforces a hold/release handshake and a maximum-tenure timeout, so no requester can starve others. It sits in front of any shared datapath that the encoder/decoder blocks drive.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant (range 2..255).
- CNT_W, 8, width of the tenure counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  1 = arbitration allowed; 0 = no new grants issued (an existing grant is unaffected).
- mode  input  1  0 = fixed priority (req[7] highest), 1 = round-robin.
- req  input  8  request vector; a requester holds its bit high for the whole tenure.
- gnt  output  8  one-hot grant, registered.
- gnt_id  output  3  binary index of the owner; valid only when gnt_valid = 1.
- gnt_valid  output  1  1 while any grant is active.
- timeout  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async, rst_n = 0): gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, state = IDLE, rr_ptr = 0, hold_cnt = 0.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If en = 1 and req != 0, pick a winner and move to BUSY.
  - gnt, gnt_id and gnt_valid become valid on the next rising edge, so grant latency is 1 cycle from req sampled.
  - If en = 0 or req = 0, stay in IDLE.
- Winner selection:
  - mode = 0: highest set index in req.
  - mode = 1: first set bit found scanning upward from rr_ptr, wrapping 7 -> 0.
  - Exactly one bit of gnt is ever set.
- BUSY:
  - hold_cnt increments each cycle and is cleared on entry.
  - If req[gnt_id] = 0: release. gnt clears next edge, go to GAP.
  - Else if hold_cnt = MAX_HOLD-1: revoke. gnt clears next edge, timeout pulses in that same cycle, go to GAP.
  - Release takes precedence over revoke when both occur in the same cycle; timeout does not pulse in that case.
  - Changes to req bits other than the owner's, and to en or mode, are ignored during BUSY.
- GAP:
  - Exactly one idle cycle with gnt = 0, then go to IDLE.
  - Guarantees a dead cycle between owners.
  - Minimum back-to-back handoff is 3 cycles from the owner dropping req to the new grant.
- rr_ptr:
  - Updated to (owner+1) mod 8 on every release or revoke, in both modes.
  - 7 wraps to 0.
- A revoked requester that still asserts req simply re-competes. In round-robin mode it is last in order; in fixed mode it may win again immediately.
- mode change: takes effect at the next IDLE decision only.
- Reset mid-grant: outputs drop asynchronously; no timeout pulse is generated.

Decomposition:
- Package arb_pkg:
  - N_REQ = 8, ID_W = 3.
  - State enum {IDLE, BUSY, GAP}.
  - Mode constants MODE_FIXED = 0, MODE_RR = 1.
- Sub-module rr_pick: purely combinational masked priority encoder.
  - Inputs: req[7:0], ptr[2:0], mode.
  - Outputs: any, idx[2:0].
  - Implemented as the priority search over a rotated request vector.
- All registers live in req_arbiter8.

Test Plan:
- Reset/idle: rst_n low with req = 8'hFF → gnt = 0, gnt_valid = 0. Release reset with en = 0 → no grant for 10 cycles.
- Fixed priority: mode = 0, req = 8'b0010_0110 → one cycle later gnt = 8'b0010_0000, gnt_id = 5. Drop req[5] → gnt = 0 next edge, one GAP cycle, then gnt = 8'b0000_0100, gnt_id = 2.
- Round-robin fairness: mode = 1, req = 8'hFF, each owner drops req after 2 cycles then re-asserts → grant order 0,1,2,...,7,0 with no repeats; gnt always one-hot.
- Timeout: MAX_HOLD = 16, req = 8'b0000_1000 held forever → gnt_id = 3 for exactly 16 cycles, then timeout = 1 for one cycle, gnt = 0, and re-grant to 3 after GAP. Also add req[1] and use mode = 1 → the next grant goes to 1.
- Simultaneous release and timeout: owner drops req in the cycle hold_cnt = 15 → timeout stays 0, normal release to GAP.
- Async reset mid-BUSY: assert rst_n = 0 between clock edges → gnt = 0 immediately, rr_ptr = 0. After release with mode = 1 and req = 8'hFF → first grant goes to index 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way request arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: highest index in fixed mode, first set bit at or
// above ptr (wrapping) in round-robin mode.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             mode,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0]  base;
  logic [N_REQ-1:0] rot;

  always_comb begin
    base = (mode == MODE_RR) ? ptr : '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[ID_W'(i) + base];
    end
    any = |req;
    idx = '0;
    // Loop order makes the last hit win: downward scan leaves the lowest rotated bit.
    if (mode == MODE_RR) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (rot[i]) idx = ID_W'(i) + base;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rot[i]) idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/req_arbiter8.sv
// Eight-requester arbiter with registered one-hot grant, hold/release handshake
// and a maximum-tenure timeout.
//
//   state | meaning
//   IDLE  | no owner; grant the picked requester when en and any req
//   BUSY  | owner holds grant; release on req drop, revoke at MAX_HOLD
//   GAP   | one dead cycle with gnt = 0 before the next decision
module req_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  hold_cnt;
  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;

  rr_pick u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .mode (mode),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && pick_any) begin
            gnt       <= ONE_HOT0 << pick_idx;
            gnt_id    <= pick_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A voluntary release wins over a revoke in the same cycle.
          if (!req[gnt_id]) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            rr_ptr    <= gnt_id + 1'b1;
            state     <= GAP;
          end else if (hold_cnt == HOLD_LAST) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            rr_ptr    <= gnt_id + 1'b1;
            state     <= GAP;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
